// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// On-board self-check harness for the single-gate lab DUTs. A start pulse
// launches an exhaustive sweep of every N_IN-bit vector on stim. Each vector
// is held for SETTLE cycles, and the DUT response is then sampled for one
// cycle and compared against the selected gate function. The block reports a
// saturating mismatch count, the first failing vector and a pass/done flag.
//
// Parameters
//   N_IN    DUT input width; the sweep covers 2**N_IN vectors (N_IN >= 1)
//   SETTLE  cycles each vector is held before it is sampled (SETTLE >= 1)
//   ERR_W   width of the saturating error counter
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begin a sweep (honoured only in IDLE or DONE)
//   gate_sel        gate under test: 000 NOT(bit0), 001 AND, 010 OR,
//                   011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 BUF(bit0).
//                   The reductions cover all N_IN bits.
//   dut_out         DUT response, looked at only in SAMPLE
//   stim            vector driven to the DUT
//   busy            high in SETTLE and SAMPLE
//   done            high in DONE
//   pass            done and no mismatch seen
//   err_count       mismatches in this sweep, saturates at all-ones
//   first_fail_vec  stim value of the first mismatch
//   first_fail_vld  first_fail_vec holds a valid capture
// -----------------------------------------------------------------------------
module gate_response_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_out,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld
);

  // The settle counter counts down from SETTLE-1 to 0. It is kept at least
  // one bit wide so that SETTLE == 1 still elaborates.
  localparam int                CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   STIM_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffvld_q, ffvld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             exp_bit;
  logic             mismatch;

  // Reference gate function. It uses the latched selection so that a change
  // to gate_sel during a sweep does not affect the result.
  always_comb begin
    exp_bit = 1'b0;
    unique case (sel_q)
      3'b000:  exp_bit = ~stim_q[0];
      3'b001:  exp_bit = &stim_q;
      3'b010:  exp_bit = |stim_q;
      3'b011:  exp_bit = ~&stim_q;
      3'b100:  exp_bit = ~|stim_q;
      3'b101:  exp_bit = ^stim_q;
      3'b110:  exp_bit = ~^stim_q;
      3'b111:  exp_bit = stim_q[0];
      default: exp_bit = 1'b0;
    endcase
  end

  assign mismatch = (dut_out != exp_bit);

  // NOTE: every *_d starts from its held value before the case statement, so
  // no path through the block leaves a signal unassigned and no latch can form.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvld_d = ffvld_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE holds its results until a new start is seen.
        if (start) begin
          sel_d   = gate_sel;
          stim_d  = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffvld_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (!(&err_q)) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!ffvld_q) begin
            ffv_d   = stim_q;
            ffvld_d = 1'b1;
          end
        end
        if (stim_q == STIM_LAST) begin
          // The final verdict counts the mismatch of this last sample too.
          // The sweep ends here, so stim stays at all-ones.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          stim_d  = stim_q + N_IN'(1);
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers are updated with non-blocking assignments only. Every
  // flop then samples its pre-edge value, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffvld_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
//
// Three checker instances with different parameters:
//   a: N_IN=1, SETTLE=1, ERR_W=8
//   b: N_IN=2, SETTLE=2, ERR_W=8
//   c: N_IN=3, SETTLE=1, ERR_W=2
// Each instance is driven by a behavioural fake DUT. The fake DUT is either
// a correct gate of a chosen type, stuck at 0, or the inverse of a chosen gate.
// For each sweep, an expected result (cycles to done, count, first fail,
// pass) is computed from a bit-counting model and pushed to a queue. When the
// DUT raises done, the entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

  localparam int B_SETTLE = 2;
  localparam int LIMIT    = 500;

  typedef struct packed {
    int   cycles;
    int   err;
    int   ffv;
    logic ffvld;
    logic pass;
    logic done;
  } res_t;

  res_t sb_q[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [2:0] a_sel = '0, b_sel = '0, c_sel = '0;
  logic       a_dut, b_dut, c_dut;
  logic [0:0] a_stim, a_ffv;
  logic [1:0] b_stim, b_ffv;
  logic [2:0] c_stim, c_ffv;
  logic       a_busy, a_done, a_pass, a_ffvld;
  logic       b_busy, b_done, b_pass, b_ffvld;
  logic       c_busy, c_done, c_pass, c_ffvld;
  logic [7:0] a_err, b_err;
  logic [1:0] c_err;

  int         a_mode = 0, b_mode = 0, c_mode = 0;
  logic [2:0] a_gate = '0, b_gate = '0, c_gate = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate model written from the popcount of the vector.
  function automatic bit model_gate(input logic [2:0] sel, input int vec, input int n);
    int ones;
    bit b0;
    ones = $countones(vec);
    b0   = vec[0];
    case (sel)
      3'd0:    return !b0;
      3'd1:    return ones == n;
      3'd2:    return ones != 0;
      3'd3:    return ones != n;
      3'd4:    return ones == 0;
      3'd5:    return (ones % 2) == 1;
      3'd6:    return (ones % 2) == 0;
      default: return b0;
    endcase
  endfunction

  // Fake DUT: mode 0 = correct gate, 1 = stuck at 0, 2 = inverted gate.
  function automatic bit fake_dut(input int mode, input logic [2:0] gate, input int vec, input int n);
    if (mode == 1) return 1'b0;
    if (mode == 2) return !model_gate(gate, vec, n);
    return model_gate(gate, vec, n);
  endfunction

  function automatic res_t predict(input int n, input int settle, input int errw,
                                   input logic [2:0] sel, input int mode, input logic [2:0] gate);
    res_t r;
    r = '0;
    for (int v = 0; v < (1 << n); v++) begin
      if (fake_dut(mode, gate, v, n) != model_gate(sel, v, n)) begin
        if (r.err < (1 << errw) - 1) r.err++;
        if (!r.ffvld) begin
          r.ffv   = v;
          r.ffvld = 1'b1;
        end
      end
    end
    r.pass   = (r.err == 0);
    r.done   = 1'b1;
    r.cycles = (1 << n) * (settle + 1);
    return r;
  endfunction

  always_comb a_dut = fake_dut(a_mode, a_gate, int'(a_stim), 1);
  always_comb b_dut = fake_dut(b_mode, b_gate, int'(b_stim), 2);
  always_comb c_dut = fake_dut(c_mode, c_gate, int'(c_stim), 3);

  gate_response_checker #(.N_IN(1), .SETTLE(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .gate_sel(a_sel), .dut_out(a_dut),
    .stim(a_stim), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_vec(a_ffv), .first_fail_vld(a_ffvld));

  gate_response_checker #(.N_IN(2), .SETTLE(B_SETTLE), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .gate_sel(b_sel), .dut_out(b_dut),
    .stim(b_stim), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_vec(b_ffv), .first_fail_vld(b_ffvld));

  gate_response_checker #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .gate_sel(c_sel), .dut_out(c_dut),
    .stim(c_stim), .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
    .first_fail_vec(c_ffv), .first_fail_vld(c_ffvld));

  // Start pulse is sampled at the edge after the first negedge. The cycle
  // count then equals the number of edges from that start edge to done.
  task automatic run_a(input logic [2:0] sel, output int cyc);
    @(negedge clk); a_sel = sel; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; cyc = 0;
    do begin @(negedge clk); cyc++; end while (!a_done && cyc < LIMIT);
  endtask

  task automatic run_c(input logic [2:0] sel, output int cyc);
    @(negedge clk); c_sel = sel; c_start = 1'b1;
    @(negedge clk); c_start = 1'b0; cyc = 0;
    do begin @(negedge clk); cyc++; end while (!c_done && cyc < LIMIT);
  endtask

  // Instance b also checks stim/busy each cycle. It can pulse start, with a
  // different gate_sel, at cycle 'poke' while the sweep is running.
  task automatic run_b(input logic [2:0] sel, input int poke, output int cyc);
    int es;
    logic eb;
    @(negedge clk); b_sel = sel; b_start = 1'b1;
    @(negedge clk); b_start = 1'b0; cyc = 0;
    do begin
      @(negedge clk); cyc++;
      es = cyc / (B_SETTLE + 1);
      if (es > 3) es = 3;
      eb = (cyc < 4 * (B_SETTLE + 1));
      n_cmp++;
      if ({b_busy, b_stim} !== {eb, es[1:0]}) begin
        n_bad++;
        $display("FAIL trace cyc %0d: got busy=%0b stim=%0d, expected busy=%0b stim=%0d",
                 cyc, b_busy, b_stim, eb, es);
      end
      if (cyc == poke) begin
        b_start = 1'b1;
        b_sel   = ~sel;
      end else begin
        b_start = 1'b0;
      end
    end while (!b_done && cyc < LIMIT);
    b_start = 1'b0;
    b_sel   = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_stim, a_busy, a_done, a_pass, a_err, a_ffv, a_ffvld} !== '0) begin
      n_bad++; $display("FAIL reset_a: got %h, expected 0", {a_stim, a_busy, a_done, a_pass, a_err, a_ffv, a_ffvld});
    end
    n_cmp++;
    if ({b_stim, b_busy, b_done, b_pass, b_err, b_ffv, b_ffvld} !== '0) begin
      n_bad++; $display("FAIL reset_b: got %h, expected 0", {b_stim, b_busy, b_done, b_pass, b_err, b_ffv, b_ffvld});
    end
    n_cmp++;
    if ({c_stim, c_busy, c_done, c_pass, c_err, c_ffv, c_ffvld} !== '0) begin
      n_bad++; $display("FAIL reset_c: got %h, expected 0", {c_stim, c_busy, c_done, c_pass, c_err, c_ffv, c_ffvld});
    end
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a_sweep(input string name, input logic [2:0] sel, input int mode, input logic [2:0] gate);
    int cyc;
    res_t e, got;
    a_mode = mode; a_gate = gate;
    sb_q.push_back(predict(1, 1, 8, sel, mode, gate));
    run_a(sel, cyc);
    e   = sb_q.pop_front();
    got = '{cyc, 32'(a_err), 32'(a_ffv), a_ffvld, a_pass, a_done};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b, expected cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b",
               name, got.cycles, got.err, got.ffv, got.ffvld, got.pass, got.done,
               e.cycles, e.err, e.ffv, e.ffvld, e.pass, e.done);
    end
  endtask

  // Sweep on instance b. If poke is not -1, start is pulsed mid-sweep.
  task automatic test_b_sweep(input string name, input logic [2:0] sel, input int mode,
                              input logic [2:0] gate, input int poke, output res_t last);
    int cyc;
    res_t e, got;
    b_mode = mode; b_gate = gate;
    sb_q.push_back(predict(2, B_SETTLE, 8, sel, mode, gate));
    run_b(sel, poke, cyc);
    e    = sb_q.pop_front();
    last = e;
    got  = '{cyc, 32'(b_err), 32'(b_ffv), b_ffvld, b_pass, b_done};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s sel=%0d mode=%0d: got cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b, expected cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b",
               name, sel, mode, got.cycles, got.err, got.ffv, got.ffvld, got.pass, got.done,
               e.cycles, e.err, e.ffv, e.ffvld, e.pass, e.done);
    end
  endtask

  task automatic test_single_bit();
    test_a_sweep("not_correct", 3'b000, 0, 3'b000);
    test_a_sweep("not_stuck0", 3'b000, 1, 3'b000);
    test_a_sweep("buf_inverted", 3'b111, 2, 3'b111);
  endtask

  task automatic test_and_vs_or();
    res_t last;
    test_b_sweep("and_vs_or", 3'b001, 0, 3'b010, -1, last);
  endtask

  task automatic test_all_gates();
    res_t last;
    for (int s = 0; s < 8; s++) begin
      test_b_sweep("gate_ok", 3'(s), 0, 3'(s), -1, last);
      test_b_sweep("gate_inv", 3'(s), 2, 3'(s), -1, last);
    end
  endtask

  task automatic test_start_while_busy();
    res_t last;
    test_b_sweep("start_busy_settle", 3'b100, 0, 3'b011, 4, last);
    test_b_sweep("start_busy_sample", 3'b101, 0, 3'b101, 6, last);
  endtask

  task automatic test_back_to_back();
    res_t last;
    test_b_sweep("b2b_first", 3'b001, 0, 3'b010, -1, last);
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({b_done, b_busy, b_pass, b_ffvld, 32'(b_err), 32'(b_ffv), 32'(b_stim)} !==
        {1'b1, 1'b0, last.pass, last.ffvld, last.err, last.ffv, 32'd3}) begin
      n_bad++;
      $display("FAIL done_hold: got done=%0b busy=%0b pass=%0b vld=%0b err=%0d ffv=%0d stim=%0d, expected done=1 busy=0 pass=%0b vld=%0b err=%0d ffv=%0d stim=3",
               b_done, b_busy, b_pass, b_ffvld, b_err, b_ffv, b_stim, last.pass, last.ffvld, last.err, last.ffv);
    end
    test_b_sweep("b2b_second", 3'b110, 0, 3'b110, -1, last);
  endtask

  task automatic test_reset_mid();
    int cnt;
    res_t last;
    b_mode = 0; b_gate = 3'b010;
    @(negedge clk); b_sel = 3'b001; b_start = 1'b1;
    @(negedge clk); b_start = 1'b0; cnt = 0;
    while (!(b_stim == 2'd2 && b_busy) && cnt < LIMIT) begin
      @(negedge clk); cnt++;
    end
    n_cmp++;
    if (cnt >= LIMIT) begin
      n_bad++; $display("FAIL reach_stim2: got stim=%0d after %0d cycles, expected stim=2", b_stim, cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_stim, b_busy, b_done, b_pass, b_err, b_ffv, b_ffvld} !== '0) begin
      n_bad++; $display("FAIL reset_mid: got %h, expected 0", {b_stim, b_busy, b_done, b_pass, b_err, b_ffv, b_ffvld});
    end
    @(negedge clk); rst_n = 1'b1;
    test_b_sweep("after_reset", 3'b001, 0, 3'b010, -1, last);
  endtask

  task automatic test_saturate();
    int cyc;
    res_t e, got;
    c_mode = 2; c_gate = 3'b101;
    sb_q.push_back(predict(3, 1, 2, 3'b101, 2, 3'b101));
    run_c(3'b101, cyc);
    e   = sb_q.pop_front();
    got = '{cyc, 32'(c_err), 32'(c_ffv), c_ffvld, c_pass, c_done};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL saturate: got cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b, expected cyc=%0d err=%0d ffv=%0d vld=%0b pass=%0b done=%0b",
               got.cycles, got.err, got.ffv, got.ffvld, got.pass, got.done,
               e.cycles, e.err, e.ffv, e.ffvld, e.pass, e.done);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_and_vs_or();
    test_all_gates();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
